// File: rtl/mac_accum_stage.sv
// MAC5 accumulate stage: aligns minifloat product terms, accumulates VEC_LEN of them, emits result on valid/ready.
// Define MAC_ACC_SAT_EN for saturating accumulation; default build wraps modulo 2**ACC_W.
module mac_accum_stage #(
  parameter int ACC_W   = 16,
  parameter int VEC_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [2:0]       mxy2,
  input  logic [2:0]       ex3,
  input  logic             sn5,
  input  logic             sn6,
  input  logic             s4,
  input  logic             sr2,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_vld,
  input  logic             acc_rdy,
  output logic             acc_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic [9:0]       mag;
  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] term;
  logic             restart;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_ext;
  logic             ovf_now;
  logic [ACC_W-1:0] sum_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;
  logic             xfer;

  always_comb begin
    mag     = {7'b0, mxy2} << ex3;
    mag_ext = ACC_W'(mag);
    term    = '0;
    if (!s4) term = (sn5 ^ sn6) ? ('0 - mag_ext) : mag_ext;
    // A term taken in IDLE or flagged sr2 starts a fresh vector from zero.
    restart = (state_q == IDLE) | sr2;
    base    = restart ? '0 : acc_q;
    sum_ext = {base[ACC_W-1], base} + {term[ACC_W-1], term};
    ovf_now = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
`ifdef MAC_ACC_SAT_EN
    if (ovf_now)
      sum_d = term[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sum_d = sum_ext[ACC_W-1:0];
`else
    sum_d = sum_ext[ACC_W-1:0];
`endif
    cnt_d = restart ? CNT_W'(1) : cnt_q + CNT_W'(1);
    ovf_d = restart ? ovf_now : (ovf_q | ovf_now);
    xfer  = in_vld & in_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (xfer) begin
            acc_q <= sum_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (cnt_d == CNT_W'(VEC_LEN)) begin
              acc_out_q <= sum_d;
              state_q   <= DRAIN;
            end else begin
              state_q   <= ACCUM;
            end
          end
        end
        DRAIN: begin
          if (acc_rdy) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_rdy  = (state_q != DRAIN);
  assign acc_vld = (state_q == DRAIN);
  assign acc_out = acc_out_q;
  assign acc_ovf = ovf_q;

endmodule
